// File: rtl/fpa_controller.sv
`default_nettype none
// ============================================================================
//  Module   : fpa_controller
//  Purpose  : Sequencing FSM for the 8-bit mini-float adder datapath
//             (load, add, iterative normalize, commit) with host handshake.
//  Revision : 1.0  initial release
// ============================================================================
module fpa_controller #(
  parameter int MANT_W         = 5,
  parameter int STEP_W         = 3,
  parameter int MAX_NORM_STEPS = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              add_except,
  input  logic              norm_except,
  input  logic [MANT_W-1:0] mant,
  output logic              load_en,
  output logic              add_en,
  output logic              norm_en,
  output logic              norm_load,
  output logic              shift_right,
  output logic              done_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        exc_code
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD       = 4'd1,
    S_ADD        = 4'd2,
    S_ADD_CHK    = 4'd3,
    S_NORM_LOAD  = 4'd4,
    S_NORM_CHK   = 4'd5,
    S_NORM_SHIFT = 4'd6,
    S_DONE       = 4'd7,
    S_EXCEPT     = 4'd8
  } state_t;

  localparam logic [STEP_W-1:0] C_MAX_STEPS = STEP_W'(MAX_NORM_STEPS);
  localparam logic [1:0]        C_EXC_OK    = 2'b00;
  localparam logic [1:0]        C_EXC_ADD   = 2'b01;
  localparam logic [1:0]        C_EXC_INF   = 2'b10;
  localparam logic [1:0]        C_EXC_NORM  = 2'b11;

  state_t            r_state, w_state_nxt;
  logic [STEP_W-1:0] r_step_cnt, w_step_cnt_nxt;
  logic              r_dir, w_dir_nxt;
  logic [1:0]        r_exc, w_exc_nxt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_step_cnt <= '0;
      r_dir      <= 1'b0;
      r_exc      <= C_EXC_OK;
    end else begin
      r_state    <= w_state_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_dir      <= w_dir_nxt;
      r_exc      <= w_exc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_step_cnt_nxt = r_step_cnt;
    w_dir_nxt      = r_dir;
    w_exc_nxt      = r_exc;
    load_en        = 1'b0;
    add_en         = 1'b0;
    norm_en        = 1'b0;
    norm_load      = 1'b0;
    done_en        = 1'b0;
    done           = 1'b0;
    busy           = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt    = S_LOAD;
          w_exc_nxt      = C_EXC_OK;
          w_step_cnt_nxt = '0;
        end
      end
      S_LOAD: begin
        load_en     = 1'b1;
        w_state_nxt = S_ADD;
      end
      S_ADD: begin
        add_en      = 1'b1;
        w_state_nxt = S_ADD_CHK;
      end
      S_ADD_CHK: begin
        if (add_except) begin
          w_exc_nxt   = C_EXC_ADD;
          w_state_nxt = S_EXCEPT;
        end else begin
          w_state_nxt = S_NORM_LOAD;
        end
      end
      S_NORM_LOAD: begin
        norm_en     = 1'b1;
        norm_load   = 1'b1;
        w_state_nxt = S_NORM_CHK;
      end
      // Checks are ordered by priority: saturation, give-up, carry, normalized, underflow.
      S_NORM_CHK: begin
        if (norm_except) begin
          w_exc_nxt   = C_EXC_INF;
          w_state_nxt = S_EXCEPT;
        end else if ((mant == '0) || (r_step_cnt == C_MAX_STEPS)) begin
          w_exc_nxt   = C_EXC_NORM;
          w_state_nxt = S_EXCEPT;
        end else if (mant[MANT_W-1]) begin
          w_dir_nxt   = 1'b1;
          w_state_nxt = S_NORM_SHIFT;
        end else if (mant[MANT_W-2]) begin
          w_state_nxt = S_DONE;
        end else begin
          w_dir_nxt   = 1'b0;
          w_state_nxt = S_NORM_SHIFT;
        end
      end
      S_NORM_SHIFT: begin
        norm_en     = 1'b1;
        if (r_step_cnt != '1) begin
          w_step_cnt_nxt = r_step_cnt + 1'b1;
        end
        w_state_nxt = S_NORM_CHK;
      end
      S_DONE: begin
        done_en     = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_EXCEPT: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign shift_right = r_dir;
  assign exc_code    = r_exc;

endmodule
`default_nettype wire

// File: doc/fpa_controller.md
Name: fpa_controller

Overview:
- Control FSM for the 8-bit mini-float adder (1 sign, 4 exponent, 3 mantissa bits).
- Sits beside the adder datapath and sequences it through LOAD, SHIFT/ADD and iterative NORMALIZE, then commits the result.
- Drives the datapath register enables and mux selects, consumes its exception flags and normalization mantissa, and runs a start/busy/done handshake with the host.

Parameters:
- MANT_W, 5, width of the datapath mantissa incl. overflow bit [4] and hidden bit [3].
- STEP_W, 3, width of the normalization step counter.
- MAX_NORM_STEPS, 4, shift iterations allowed before a normalization-failure exception.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  reset, asynchronous, active-low.
- start  input  1  host request; sampled only in IDLE.
- add_except  input  1  datapath add-stage exception (zero/overflow/underflow); valid in ADD_CHK.
- norm_except  input  1  datapath exponent saturated (Inf/NaN); valid in NORM_CHK.
- mant  input  MANT_W  normalization-register mantissa; valid in NORM_CHK.
- load_en  output  1  operand register enable.
- add_en  output  1  add-stage register enable.
- norm_en  output  1  normalization register enable.
- norm_load  output  1  normalization mux select: 1 = load add result, 0 = shifted value.
- shift_right  output  1  shift direction: 1 = right/exp+1, 0 = left/exp-1.
- done_en  output  1  result register enable.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- exc_code  output  2  00 ok, 01 add exception, 10 Inf/NaN, 11 normalization failure; held until the next start.

Behaviour:
- Reset (clr=0, async): state=IDLE, step_cnt=0, dir=0, exc_code=00. All outputs 0 immediately, including mid-operation; no partial done.
- Moore outputs: decoded from registered state. shift_right = registered dir flag, so it is stable throughout NORM_SHIFT.
- Per-state outputs and transitions:
  - IDLE: busy=0. start=1 → LOAD; clear exc_code and step_cnt.
  - LOAD: load_en=1, busy=1 → ADD.
  - ADD: add_en=1 → ADD_CHK.
  - ADD_CHK: no enables. add_except=1 → EXCEPT with code 01; else → NORM_LOAD.
  - NORM_LOAD: norm_en=1, norm_load=1 → NORM_CHK.
  - NORM_CHK: no enables. Checks in priority order:
    1. norm_except → EXCEPT, code 10.
    2. mant==0 or step_cnt==MAX_NORM_STEPS → EXCEPT, code 11.
    3. mant[4]=1 → dir=1, go NORM_SHIFT.
    4. mant[4:3]=01 → DONE.
    5. else (mant[4:3]=00) → dir=0, go NORM_SHIFT.
  - NORM_SHIFT: norm_en=1, norm_load=0; step_cnt += 1 (saturating) → NORM_CHK.
  - DONE: done_en=1, done=1 → IDLE.
  - EXCEPT: done=1, done_en=0 (result register unchanged) → IDLE.
- Latency, with start sampled at edge 0:
  - busy rises in cycle 1.
  - Normalized result: done in cycle 6 + 2k, k = shift count.
  - Add exception: done in cycle 4.
- start while busy: ignored; no queuing.
- start held high: re-triggers on the cycle after DONE/EXCEPT returns to IDLE, i.e. one idle cycle between operations.
- No two datapath enables are ever asserted in the same cycle. norm_load=1 only in NORM_LOAD.
- step_cnt never wraps.

Test Plan:
- Reset mid-op: pulse clr=0 while in NORM_SHIFT → all outputs 0 same cycle; after release, state IDLE, busy=0.
- Already normalized: start; ADD_CHK add_except=0; NORM_CHK mant=01010 → done in cycle 6, done_en=1 for exactly that cycle, exc_code=00, no NORM_SHIFT.
- Carry-out: NORM_CHK mant=10110, then 01011 → one NORM_SHIFT with shift_right=1, norm_load=0; done in cycle 8, exc_code=00.
- Cancellation: NORM_CHK mant sequence 00010 → 00100 → 01000 → two left shifts (shift_right=0); done in cycle 10.
- Exceptions:
  - add_except=1 in ADD_CHK → done cycle 4, exc_code=01, done_en never asserted.
  - norm_except=1 in NORM_CHK → exc_code=10.
  - mant stuck at 00001 → 4 shifts, then exc_code=11.
- Handshake: start held high for 20 cycles → busy never drops mid-op, back-to-back ops separated by exactly one IDLE cycle, extra start ignored while busy.
